uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Parametrised next-generation UART receiver for the IO/uart subsystem.
- Oversampled serial input; configurable data width, parity and stop-bit count; false-start rejection.
- Received words carry per-word parity/framing error flags and are buffered in an internal FIFO with a valid/read handshake.
- Sits between the rx pin and the CPU IO register interface; driven by the same baud clock-enable generator as the existing receiver.

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- OVERSAMPLE, 16: clken ticks per bit; even, 8..32.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of 2, 2..16.

Ports:
- clk_50m  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clken  in  1  oversample tick, one clk_50m cycle wide, OVERSAMPLE per bit.
- rx  in  1  asynchronous serial input, idle high.
- rd_en  in  1  pop head word; ignored when rdy = 0.
- err_clr  in  1  clears the sticky overrun flag.
- data  out  DATA_BITS  head-of-FIFO data, LSB = first received bit.
- parity_err  out  1  head word failed parity; always 0 when PARITY = 0.
- frame_err  out  1  head word had a low stop bit.
- rdy  out  1  FIFO non-empty.
- overrun  out  1  sticky; a word was dropped because the FIFO was full.
- break_det  out  1  one-cycle pulse when a break is recognised.

Behaviour:
- Reset (async assert, sync release):
  - rx synchroniser = 1, state = IDLE, counters = 0, FIFO empty.
  - data = 0, rdy = 0, parity_err = 0, frame_err = 0, overrun = 0, break_det = 0.
- rx passes through a 2-flop synchroniser; all sampling uses the synchronised value (rxs). Added latency is 2 clk_50m cycles.
- State and counter updates occur only on clken, except the FIFO, overrun and break_det logic.
- IDLE:
  - On clken with rxs = 0, go to START with sample = 1.
- START:
  - sample increments each tick.
  - At sample = OVERSAMPLE/2 (mid-bit), test rxs:
    - rxs = 1: false start; return to IDLE.
    - rxs = 0: go to DATA; sample = 1, bitpos = 0, shift register cleared.
  - All later samples occur when sample = OVERSAMPLE, which is mid-bit.
- DATA:
  - On each mid-bit sample, store rxs at scratch[bitpos], then increment bitpos.
  - After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY:
  - pe = (XOR of data bits XOR sampled bit) != odd-parity-expected.
  - Odd: total number of ones including the parity bit must be odd. Even: that total must be even.
- STOP:
  - Sample STOP_BITS stop bits; fe = 1 if any sampled stop bit is 0.
  - On the last stop-bit mid-sample, push {scratch, pe, fe} and return to IDLE immediately. The remaining half bit is not waited for, which allows resync on the next start edge.
- Break:
  - Condition: fe = 1, all data bits = 0, and parity bit = 0 (if parity is present).
  - Action: assert break_det for one cycle and enter BRK. The word is still pushed with fe = 1.
  - BRK returns to IDLE only after rxs has been sampled 1 on a clken.
- FIFO push: occurs in the same clk_50m cycle as the final stop sample.
  - Full, no simultaneous pop: word dropped, overrun set.
  - Full with simultaneous pop: push and pop both succeed, no overrun.
- FIFO outputs: data, parity_err and frame_err are registered views of the head entry, valid whenever rdy = 1.
- Pop: rd_en with rdy = 1 advances the head; new head values appear on the next cycle. Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.
- err_clr: clears overrun. If err_clr and a new overrun occur in the same cycle, overrun stays set.
- rx activity during IDLE/START while the FIFO is full still parses frames; only the push is dropped.

Test Plan:
- 8N1, OVERSAMPLE = 16, clken every cycle: send 0xA5 -> rdy rises; data = 0xA5, parity_err = 0, frame_err = 0; rd_en -> rdy = 0.
- Glitch: rx low for 5 ticks, then high -> state returns to IDLE, no push, rdy stays 0.
- PARITY = 2 (even): send 0x03 with parity bit 1 -> parity_err = 1. Send 0x03 with parity bit 0 -> parity_err = 0.
- STOP_BITS = 2: second stop bit low, data 0x7E -> word pushed, data = 0x7E, frame_err = 1. Hold rx low for 12 bit times -> one break_det pulse; no new start is accepted until rx goes high.
- FIFO_DEPTH = 4: send 5 words 0x01..0x05 with no reads -> overrun = 1; reads return 0x01..0x04 in order. err_clr -> overrun = 0.
- Reset: assert rst_n low mid-frame -> all outputs 0 and FIFO empty. Release reset, send 0x5A -> data = 0x5A, received cleanly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with false-start rejection, break detection and a
// small word FIFO carrying per-word parity/framing error flags.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rdy,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int SW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    localparam logic [SW-1:0] OS_FULL   = SW'(OVERSAMPLE);
    localparam logic [SW-1:0] OS_HALF   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMPLE_1  = SW'(1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
        logic ones_odd;
        ones_odd = (^d) ^ p;
        if (PARITY == 1)
            return ~ones_odd;
        else if (PARITY == 2)
            return ones_odd;
        else
            return 1'b0;
    endfunction

    logic                 rx_meta_q, rxs_q;
    state_t               state_q, state_d;
    logic [SW-1:0]        sample_q, sample_d;
    logic [BW-1:0]        bitpos_q, bitpos_d;
    logic [DATA_BITS-1:0] scratch_q, scratch_d;
    logic                 par_q, par_d;
    logic                 fe_q, fe_d;
    logic                 stop_q, stop_d;
    logic                 brk_q;
    logic                 ovr_q;
    logic [AW:0]          wptr_q, rptr_q;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];

    logic                 push, brk_hit, fe_now, mid;
    logic                 empty, full, pop, wr;
    logic [EW-1:0]        entry, head;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        bitpos_d  = bitpos_q;
        scratch_d = scratch_q;
        par_d     = par_q;
        fe_d      = fe_q;
        stop_d    = stop_q;
        push      = 1'b0;
        brk_hit   = 1'b0;
        fe_now    = fe_q | ~rxs_q;
        mid       = (sample_q == OS_FULL);
        if (clken) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_d  = S_START;
                        sample_d = SAMPLE_1;
                    end
                end
                S_START: begin
                    if (sample_q == OS_HALF) begin
                        if (rxs_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            sample_d  = SAMPLE_1;
                            bitpos_d  = '0;
                            scratch_d = '0;
                            par_d     = 1'b0;
                            fe_d      = 1'b0;
                        end
                    end else begin
                        sample_d = sample_q + SAMPLE_1;
                    end
                end
                S_DATA: begin
                    if (mid) begin
                        scratch_d[bitpos_q] = rxs_q;
                        bitpos_d = bitpos_q + BW'(1);
                        sample_d = SAMPLE_1;
                        if (bitpos_q == LAST_BIT) begin
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        sample_d = sample_q + SAMPLE_1;
                    end
                end
                S_PARITY: begin
                    if (mid) begin
                        par_d    = rxs_q;
                        sample_d = SAMPLE_1;
                        stop_d   = 1'b0;
                        state_d  = S_STOP;
                    end else begin
                        sample_d = sample_q + SAMPLE_1;
                    end
                end
                S_STOP: begin
                    if (mid) begin
                        sample_d = SAMPLE_1;
                        fe_d     = fe_now;
                        // Leave on the mid-sample of the last stop bit so the next start edge is caught.
                        if (stop_q == LAST_STOP) begin
                            push    = 1'b1;
                            brk_hit = fe_now && (scratch_q == '0) && !par_q;
                            state_d = brk_hit ? S_BRK : S_IDLE;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + SAMPLE_1;
                    end
                end
                S_BRK: begin
                    if (rxs_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sample_q  <= '0;
            bitpos_q  <= '0;
            scratch_q <= '0;
            par_q     <= 1'b0;
            fe_q      <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            bitpos_q  <= bitpos_d;
            scratch_q <= scratch_d;
            par_q     <= par_d;
            fe_q      <= fe_d;
            stop_q    <= stop_d;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = rd_en && !empty;
    assign wr    = push && (!full || pop);
    assign entry = {scratch_q, parity_fail(scratch_q, par_q), fe_now};

    always_ff @(posedge clk_50m) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && full && !pop)
                ovr_q <= 1'b1;
            else if (err_clr)
                ovr_q <= 1'b0;
            brk_q <= push && brk_hit;
        end
    end

    assign head       = mem_q[rptr_q[AW-1:0]];
    assign rdy        = !empty;
    assign data       = empty ? '0 : head[EW-1:2];
    assign parity_err = empty ? 1'b0 : head[1];
    assign frame_err  = empty ? 1'b0 : head[0];
    assign overrun    = ovr_q;
    assign break_det  = brk_q;

endmodule
